pipe_stage_reg: RTL and testbench

Parametrised, payload-agnostic pipeline stage register that replaces the per-stage hand-written registers (F/D/E/M/W) with one reusable block. It adds a valid/ready handshake with an optional 2-entry skid buffer, so backpressure does not form a combinational ready chain. It also provides flush (bubble insertion), stall and saturating performance counters. It sits between any two pipeline stages; the stage payload is packed into one vector by the instantiating stage.

---
 rtl/pipe_pkg.sv | 45 ++++
 rtl/sat_counter.sv | 28 ++
 rtl/pipe_stage_reg.sv | 127 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types: stage state encoding, register/width constants, packed stage payloads
package pipe_pkg;

  localparam int PC_WIDTH  = 32;
  localparam int CPU_WIDTH = 64;
  localparam int REG_WIDTH = 5;

  // x0 doubles as "no destination": writes to it are architecturally discarded
  localparam logic [REG_WIDTH-1:0] RNONE = '0;

  // Encoding equals the number of held entries, so it drives occupancy directly
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0]  pc;
    logic [31:0]          instr;
  } fd_payload_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0]  pc;
    logic [REG_WIDTH-1:0] rd;
    logic [CPU_WIDTH-1:0] rs1_val;
    logic [CPU_WIDTH-1:0] rs2_val;
  } de_payload_t;

  typedef struct packed {
    logic [REG_WIDTH-1:0] rd;
    logic [CPU_WIDTH-1:0] result;
  } em_payload_t;

  typedef struct packed {
    logic [REG_WIDTH-1:0] rd;
    logic [CPU_WIDTH-1:0] wb_val;
  } mw_payload_t;

  localparam int FD_W = $bits(fd_payload_t);
  localparam int DE_W = $bits(de_payload_t);
  localparam int EM_W = $bits(em_payload_t);
  localparam int MW_W = $bits(mw_payload_t);

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Ports: clk_i clock; rst_n_i async active-low reset; inc count enable;
//        clr synchronous clear (wins over inc); count current value.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - reusable valid/ready pipeline stage register with optional skid entry
// Ports: clk_i/rst_n_i clock and async active-low reset; flush_i drops held entries;
//        stall_i freezes the stage; in_valid_i/in_ready_o/in_data_i upstream handshake;
//        out_valid_o/out_ready_i/out_data_o downstream handshake; occupancy_o held entries;
//        cnt_clr_i clears counters; stall_cnt_o/starve_cnt_o saturating event counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W     = 64,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = {DATA_W{1'b0}},
  parameter int                 SKID_EN    = 1,
  parameter int                 CNT_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  starve_cnt_o
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire, out_fire;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_data_o  = main_q;
  assign occupancy_o = state_q;

  // With the skid entry, ready depends only on registered state, which breaks
  // the combinational ready chain; without it, ready looks through to downstream.
  always_comb begin
    in_ready_o = 1'b0;
    if (SKID_EN != 0) begin
      in_ready_o = (state_q != ST_FULL) && !stall_i;
    end else begin
      in_ready_o = !stall_i && (!out_valid_o || out_ready_i);
    end
  end

  assign in_fire  = in_valid_i && in_ready_o;
  assign out_fire = out_valid_o && out_ready_i && !stall_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else if (!stall_i) begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_HALF;
            main_d  = in_data_i;
          end
        end
        ST_HALF: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            // Only reachable with the skid entry: without it in_fire implies out_fire here
            if (SKID_EN != 0) begin
              state_d = ST_FULL;
              skid_d  = in_data_i;
            end
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE_VAL;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d = ST_HALF;
            main_d  = skid_q;
            skid_d  = BUBBLE_VAL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE_VAL;
          skid_d  = BUBBLE_VAL;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc     (stall_i && !flush_i),
    .clr     (cnt_clr_i),
    .count   (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_starve_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc     (!out_valid_o && out_ready_i),
    .clr     (cnt_clr_i),
    .count   (starve_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg, skid and non-skid variants side by side
module tb_pipe_stage_reg;

  localparam int              DW  = 16;
  localparam logic [DW-1:0]   BUB = 16'hDEAD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          stall = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          cnt_clr = 1'b0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      passes++;
    end
  endtask

  // Instance 0: no skid entry, 4-bit counters. Instance 1: skid entry, 16-bit counters.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int SKID = (g == 1) ? 1 : 0;
    localparam int CW   = (g == 1) ? 16 : 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occ;
    logic [CW-1:0] stall_cnt, starve_cnt;

    pipe_stage_reg #(
      .DATA_W(DW), .BUBBLE_VAL(BUB), .SKID_EN(SKID), .CNT_W(CW)
    ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .stall_i(stall),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .occupancy_o(occ), .cnt_clr_i(cnt_clr),
      .stall_cnt_o(stall_cnt), .starve_cnt_o(starve_cnt)
    );

    // Reference: a bounded FIFO of accepted payloads plus two saturating integer counts.
    logic [DW-1:0] q[$];
    int            stall_m = 0;
    int            starve_m = 0;

    always @(negedge clk) begin
      bit rdy;
      bit ofire;
      if (!rst_n) begin
        q.delete();
        stall_m  = 0;
        starve_m = 0;
      end
      if (SKID == 1) rdy = (q.size() < 2) && !stall;
      else           rdy = !stall && (q.size() == 0 || out_ready);
      check($sformatf("g%0d.in_ready", g), 64'(in_ready), 64'(rdy));
      check($sformatf("g%0d.out_valid", g), 64'(out_valid), 64'(q.size() != 0));
      check($sformatf("g%0d.occupancy", g), 64'(occ), 64'(q.size()));
      check($sformatf("g%0d.out_data", g), 64'(out_data), 64'((q.size() != 0) ? q[0] : BUB));
      check($sformatf("g%0d.stall_cnt", g), 64'(stall_cnt), 64'(stall_m));
      check($sformatf("g%0d.starve_cnt", g), 64'(starve_cnt), 64'(starve_m));
      if (rst_n) begin
        ofire = (q.size() != 0) && out_ready && !stall;
        if (cnt_clr) stall_m = 0;
        else if (stall && !flush && stall_m < CMAX) stall_m++;
        if (cnt_clr) starve_m = 0;
        else if (q.size() == 0 && out_ready && starve_m < CMAX) starve_m++;
        if (flush) begin
          q.delete();
        end else begin
          if (ofire) void'(q.pop_front());
          if (in_valid && rdy) q.push_back(in_data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // Streaming 1..8 at full rate
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = DW'(i);
      cyc();
    end
    in_valid = 1'b0;
    repeat (3) cyc();

    // Backpressure: A, B, C with downstream blocked
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 16'h00A0; cyc();
    in_data = 16'h00B0; cyc();
    in_data = 16'h00C0; cyc();
    check("bp.occupancy", 64'(g_dut[1].occ), 64'd2);
    check("bp.in_ready", 64'(g_dut[1].in_ready), 64'd0);
    out_ready = 1'b1;
    repeat (3) cyc();
    in_valid = 1'b0;
    repeat (3) cyc();

    // Stall versus flush
    cnt_clr  = 1'b1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h0A0A; cyc();
    in_data = 16'h0B0B; cyc();
    cnt_clr  = 1'b0;
    in_valid = 1'b0;
    stall    = 1'b1;
    out_ready = 1'b1;
    repeat (3) cyc();
    check("stall.cnt3", 64'(g_dut[1].stall_cnt), 64'd3);
    check("stall.held", 64'(g_dut[1].occ), 64'd2);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    stall = 1'b0;
    out_ready = 1'b0;
    check("flush.occupancy", 64'(g_dut[1].occ), 64'd0);
    check("flush.out_data", 64'(g_dut[1].out_data), 64'(BUB));
    check("flush.stall_cnt", 64'(g_dut[1].stall_cnt), 64'd3);

    // Flush wins over a same-cycle input
    in_valid = 1'b1;
    in_data = 16'h1111; cyc();
    in_data = 16'h0D0D; flush = 1'b1; cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flushin.occupancy", 64'(g_dut[1].occ), 64'd0);

    // Starve counter saturation on the 4-bit instance
    out_ready = 1'b1;
    cnt_clr = 1'b1; cyc();
    cnt_clr = 1'b0;
    repeat (20) cyc();
    check("sat.starve15", 64'(g_dut[0].starve_cnt), 64'd15);
    cnt_clr = 1'b1; cyc();
    cnt_clr = 1'b0;
    check("sat.cleared", 64'(g_dut[0].starve_cnt), 64'd0);

    // Combinational ready on the non-skid instance while it holds an entry
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 16'h0E0E; cyc();
    in_valid = 1'b0;
    #1 check("comb.ready_lo", 64'(g_dut[0].in_ready), 64'd0);
    out_ready = 1'b1;
    #1 check("comb.ready_hi", 64'(g_dut[0].in_ready), 64'd1);
    repeat (3) cyc();

    // Asynchronous reset while full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 16'h0F0F; cyc();
    in_data = 16'h0707; cyc();
    in_valid = 1'b0;
    check("rst.full_before", 64'(g_dut[1].occ), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rst.out_valid", 64'(g_dut[1].out_valid), 64'd0);
    check("rst.occupancy", 64'(g_dut[1].occ), 64'd0);
    check("rst.out_data", 64'(g_dut[1].out_data), 64'(BUB));
    cyc();
    rst_n = 1'b1;
    #1 check("rst.in_ready", 64'(g_dut[1].in_ready), 64'd1);
    cyc();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = DW'($urandom);
      out_ready = ($urandom % 3) != 0;
      stall     = ($urandom % 10) == 0;
      flush     = ($urandom % 25) == 0;
      cnt_clr   = ($urandom % 50) == 0;
      cyc();
    end
    in_valid = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    cnt_clr = 1'b0;
    out_ready = 1'b1;
    repeat (4) cyc();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
